// File: rtl/commit_ctl.sv
// In-order commit controller for the ROB head: retires one instruction per cycle at most,
// handshakes stores with the store buffer, raises flush on mispredict/exception, counts instret.
//
// state      | meaning
// RUN        | examine the committable head and retire, stall or flush
// STORE_WAIT | head store waiting for store-buffer acceptance
// FLUSH      | one-cycle flush; except_o reflects the latched exception
module commit_ctl #(
  parameter int ILEN        = 32,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_LEN = 4,
  parameter int EXCEPT_LEN  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   rob_valid_i,
  input  logic                   rob_res_ready_i,
  input  logic [ILEN-1:0]        rob_instr_i,
  input  logic [ROB_IDX_LEN-1:0] rob_head_idx_i,
  input  logic                   rob_except_i,
  input  logic [EXCEPT_LEN-1:0]  rob_except_code_i,
  input  logic                   rob_mispred_i,
  output logic                   rob_ready_o,
  input  logic                   sb_store_committing_i,
  output logic                   sb_commit_o,
  output logic                   rf_we_o,
  output logic [ROB_IDX_LEN-1:0] comm_idx_o,
  output logic                   flush_o,
  output logic                   except_o,
  output logic [EXCEPT_LEN-1:0]  except_code_o,
  output logic [XLEN-1:0]        instret_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t                state_q, state_d;
  logic                  exc_flag_q, exc_flag_d;
  logic [EXCEPT_LEN-1:0] exc_code_q, exc_code_d;
  logic [XLEN-1:0]       instret_q;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       committable;
  logic       is_store;
  logic       writes_rd;
  logic       unused_instr;

  assign opcode       = rob_instr_i[6:0];
  assign rd           = rob_instr_i[11:7];
  assign committable  = rob_valid_i & rob_res_ready_i;
  assign is_store     = (opcode == OP_STORE);
  assign writes_rd    = (opcode != OP_STORE) && (opcode != OP_BRANCH) &&
                        (opcode != OP_FENCE) && (rd != 5'd0);
  assign unused_instr = ^rob_instr_i[ILEN-1:12];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      exc_flag_q <= 1'b0;
      exc_code_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      exc_flag_q <= exc_flag_d;
      exc_code_q <= exc_code_d;
      if (rob_ready_o) instret_q <= instret_q + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  // Outputs are forced idle while reset is held so a pending store request drops at once.
  always_comb begin
    state_d     = state_q;
    exc_flag_d  = exc_flag_q;
    exc_code_d  = exc_code_q;
    rob_ready_o = 1'b0;
    sb_commit_o = 1'b0;
    flush_o     = 1'b0;
    if (rst_n_i) begin
      unique case (state_q)
        RUN: begin
          if (committable) begin
            if (rob_except_i) begin
              exc_flag_d = 1'b1;
              exc_code_d = rob_except_code_i;
              state_d    = FLUSH;
            end else if (is_store) begin
              sb_commit_o = 1'b1;
              if (sb_store_committing_i) rob_ready_o = 1'b1;
              else                       state_d     = STORE_WAIT;
            end else if (rob_mispred_i) begin
              rob_ready_o = 1'b1;
              exc_flag_d  = 1'b0;
              state_d     = FLUSH;
            end else begin
              rob_ready_o = 1'b1;
            end
          end
        end
        STORE_WAIT: begin
          sb_commit_o = 1'b1;
          if (sb_store_committing_i) begin
            rob_ready_o = 1'b1;
            state_d     = RUN;
          end
        end
        FLUSH: begin
          flush_o = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign rf_we_o       = rob_ready_o & writes_rd;
  assign comm_idx_o    = rob_head_idx_i;
  assign except_o      = flush_o & exc_flag_q;
  assign except_code_o = flush_o ? exc_code_q : '0;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_commit_ctl.sv
// Directed bench for commit_ctl: ALU stream, stores with delayed/immediate ack,
// mispredict and exception flushes, reset during STORE_WAIT and x0 writes.
module tb_commit_ctl;

  localparam int ILEN = 32, XLEN = 64, RIL = 4, EL = 6;

  localparam logic [31:0] I_ADDI_X5 = 32'h00100293;
  localparam logic [31:0] I_ADDI_X0 = 32'h00100013;
  localparam logic [31:0] I_SW      = 32'h00512023;
  localparam logic [31:0] I_BEQ     = 32'h00000063;
  localparam logic [31:0] I_LW_X6   = 32'h00002303;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            rob_valid_i, rob_res_ready_i, rob_except_i, rob_mispred_i;
  logic [ILEN-1:0] rob_instr_i;
  logic [RIL-1:0]  rob_head_idx_i;
  logic [EL-1:0]   rob_except_code_i;
  logic            sb_store_committing_i;
  logic            rob_ready_o, sb_commit_o, rf_we_o, flush_o, except_o;
  logic [RIL-1:0]  comm_idx_o;
  logic [EL-1:0]   except_code_o;
  logic [XLEN-1:0] instret_o;

  int n_checks = 0;
  int n_errors = 0;

  commit_ctl #(.ILEN(ILEN), .XLEN(XLEN), .ROB_IDX_LEN(RIL), .EXCEPT_LEN(EL)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rob_valid_i(rob_valid_i), .rob_res_ready_i(rob_res_ready_i),
    .rob_instr_i(rob_instr_i), .rob_head_idx_i(rob_head_idx_i),
    .rob_except_i(rob_except_i), .rob_except_code_i(rob_except_code_i),
    .rob_mispred_i(rob_mispred_i), .rob_ready_o(rob_ready_o),
    .sb_store_committing_i(sb_store_committing_i), .sb_commit_o(sb_commit_o),
    .rf_we_o(rf_we_o), .comm_idx_o(comm_idx_o), .flush_o(flush_o),
    .except_o(except_o), .except_code_o(except_code_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic head(input logic v, input logic [31:0] instr, input logic [3:0] idx);
    rob_valid_i     = v;
    rob_res_ready_i = v;
    rob_instr_i     = instr;
    rob_head_idx_i  = idx;
  endtask

  initial begin
    rst_n_i = 1'b0;
    head(1'b0, 32'h0, 4'd0);
    rob_except_i = 1'b0; rob_except_code_i = '0; rob_mispred_i = 1'b0;
    sb_store_committing_i = 1'b0;
    #2;
    check("rst_rob_ready", 64'(rob_ready_o), 64'd0);
    check("rst_sb_commit", 64'(sb_commit_o), 64'd0);
    check("rst_flush", 64'(flush_o), 64'd0);
    check("rst_except", 64'(except_o), 64'd0);
    check("rst_except_code", 64'(except_code_o), 64'd0);
    check("rst_instret", instret_o, 64'd0);
    step(); step();
    rst_n_i = 1'b1;
    step();

    // Four back-to-back ADDI x5
    for (int i = 0; i < 4; i++) begin
      head(1'b1, I_ADDI_X5, 4'(i + 3));
      #1;
      check("alu_pop", 64'(rob_ready_o), 64'd1);
      check("alu_rf_we", 64'(rf_we_o), 64'd1);
      check("alu_idx", 64'(comm_idx_o), 64'(i + 3));
      check("alu_instret_pre", instret_o, 64'(i));
      step();
    end
    head(1'b0, 32'h0, 4'd0);
    #1;
    check("alu_instret", instret_o, 64'd4);
    check("idle_pop", 64'(rob_ready_o), 64'd0);

    // Store, ack arrives on the 4th cycle
    head(1'b1, I_SW, 4'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stw_sb_commit", 64'(sb_commit_o), 64'd1);
      check("stw_no_pop", 64'(rob_ready_o), 64'd0);
      step();
    end
    sb_store_committing_i = 1'b1;
    #1;
    check("stw_sb_commit4", 64'(sb_commit_o), 64'd1);
    check("stw_pop", 64'(rob_ready_o), 64'd1);
    check("stw_rf_we", 64'(rf_we_o), 64'd0);
    step();
    head(1'b0, 32'h0, 4'd0);
    sb_store_committing_i = 1'b0;
    #1;
    check("stw_instret", instret_o, 64'd5);
    check("stw_sb_idle", 64'(sb_commit_o), 64'd0);

    // Store with immediate ack, then an ADDI proves the FSM stayed in RUN
    head(1'b1, I_SW, 4'd2);
    sb_store_committing_i = 1'b1;
    #1;
    check("sti_pop", 64'(rob_ready_o), 64'd1);
    check("sti_sb_commit", 64'(sb_commit_o), 64'd1);
    step();
    sb_store_committing_i = 1'b0;
    head(1'b1, I_ADDI_X5, 4'd3);
    #1;
    check("sti_run_pop", 64'(rob_ready_o), 64'd1);
    check("sti_run_sb", 64'(sb_commit_o), 64'd0);
    step();
    head(1'b0, 32'h0, 4'd0);
    #1;
    check("sti_instret", instret_o, 64'd7);

    // Mispredicted BEQ
    head(1'b1, I_BEQ, 4'd4);
    rob_mispred_i = 1'b1;
    #1;
    check("mis_pop", 64'(rob_ready_o), 64'd1);
    check("mis_rf_we", 64'(rf_we_o), 64'd0);
    step();
    head(1'b0, 32'h0, 4'd0);
    rob_mispred_i = 1'b0;
    #1;
    check("mis_flush", 64'(flush_o), 64'd1);
    check("mis_except", 64'(except_o), 64'd0);
    check("mis_instret", instret_o, 64'd8);
    step();
    check("mis_flush_done", 64'(flush_o), 64'd0);

    // Excepting LW, code 0x05
    head(1'b1, I_LW_X6, 4'd5);
    rob_except_i = 1'b1;
    rob_except_code_i = 6'h05;
    #1;
    check("exc_no_pop", 64'(rob_ready_o), 64'd0);
    check("exc_rf_we", 64'(rf_we_o), 64'd0);
    step();
    head(1'b0, 32'h0, 4'd0);
    rob_except_i = 1'b0;
    rob_except_code_i = '0;
    #1;
    check("exc_flush", 64'(flush_o), 64'd1);
    check("exc_except", 64'(except_o), 64'd1);
    check("exc_code", 64'(except_code_o), 64'h05);
    check("exc_instret", instret_o, 64'd8);
    step();
    check("exc_after_flush", 64'(flush_o), 64'd0);
    check("exc_after_except", 64'(except_o), 64'd0);
    check("exc_after_code", 64'(except_code_o), 64'd0);
    check("exc_after_pop", 64'(rob_ready_o), 64'd0);
    check("exc_after_instret", instret_o, 64'd8);

    // Head valid drops while in STORE_WAIT: request must hold, ack still pops
    head(1'b1, I_SW, 4'd6);
    #1;
    step();
    head(1'b0, I_SW, 4'd6);
    #1;
    check("swv_hold", 64'(sb_commit_o), 64'd1);
    check("swv_no_pop", 64'(rob_ready_o), 64'd0);
    sb_store_committing_i = 1'b1;
    #1;
    check("swv_pop", 64'(rob_ready_o), 64'd1);
    step();
    sb_store_committing_i = 1'b0;
    #1;
    check("swv_instret", instret_o, 64'd9);
    check("swv_sb_idle", 64'(sb_commit_o), 64'd0);

    // Reset during STORE_WAIT, then ADDI x0
    head(1'b1, I_SW, 4'd7);
    #1;
    step();
    check("rsw_in_wait", 64'(sb_commit_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("rsw_sb_commit", 64'(sb_commit_o), 64'd0);
    check("rsw_instret", instret_o, 64'd0);
    check("rsw_flush", 64'(flush_o), 64'd0);
    #1;
    rst_n_i = 1'b1;
    head(1'b1, I_ADDI_X0, 4'd8);
    #1;
    check("x0_pop", 64'(rob_ready_o), 64'd1);
    check("x0_rf_we", 64'(rf_we_o), 64'd0);
    check("x0_sb_commit", 64'(sb_commit_o), 64'd0);
    step();
    head(1'b0, 32'h0, 4'd0);
    #1;
    check("x0_instret", instret_o, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
